hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_if.sv | 41 ++++
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Pipeline <-> hazard controller signal bundle.
// The pipeline side (master) supplies decode/execute status; the controller
// side (slave) returns write enables, flushes and mult/div status.
interface hazard_if;
   logic        IDEX_MemRead_in;
   logic [4:0]  IDEX_RegisterRt_in;
   logic [4:0]  IFID_RegisterRs_in;
   logic [4:0]  IFID_RegisterRt_in;
   logic        IFID_UsesRt_in;
   logic        Branch_taken_in;
   logic        Jump_in;
   logic        MulDiv_start_in;

   logic        PcWrite_out;
   logic        IFID_Write_out;
   logic        IDEX_Write_out;
   logic        IFID_Flush_out;
   logic        IDEX_Flush_out;
   logic        EXMEM_Flush_out;
   logic        MulDiv_busy_out;
   logic        MulDiv_done_out;
   logic [15:0] Stall_cnt_out;

   modport master (
      output IDEX_MemRead_in, IDEX_RegisterRt_in, IFID_RegisterRs_in,
             IFID_RegisterRt_in, IFID_UsesRt_in, Branch_taken_in,
             Jump_in, MulDiv_start_in,
      input  PcWrite_out, IFID_Write_out, IDEX_Write_out, IFID_Flush_out,
             IDEX_Flush_out, EXMEM_Flush_out, MulDiv_busy_out,
             MulDiv_done_out, Stall_cnt_out
   );

   modport slave (
      input  IDEX_MemRead_in, IDEX_RegisterRt_in, IFID_RegisterRs_in,
             IFID_RegisterRt_in, IFID_UsesRt_in, Branch_taken_in,
             Jump_in, MulDiv_start_in,
      output PcWrite_out, IFID_Write_out, IDEX_Write_out, IFID_Flush_out,
             IDEX_Flush_out, EXMEM_Flush_out, MulDiv_busy_out,
             MulDiv_done_out, Stall_cnt_out
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes and a
// fixed-latency mult/div stall with a done pulse, plus a saturating count
// of cycles in which the PC was held.
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | normal issue; branch > mult/div start > load-use > jump priority
// BUSY  | mult/div in flight; cnt counts down, done pulses when cnt == 0
module hazard_ctrl #(
   parameter int unsigned MULDIV_LAT = 32
) (
   input logic     clk,
   input logic     reset,
   hazard_if.slave hz
);

   typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_t;

   // Start cycle is the first stall cycle, so the counter covers the rest.
   localparam logic [7:0] LAT_M1 = 8'(MULDIV_LAT - 1);

   state_t      state, stateNext;
   logic [7:0]  cnt, cntNext;
   logic [15:0] stallCnt;
   logic        loadUse;
   logic        rtMatchRs, rtMatchRt;

   logic pcWrite, ifidWrite, idexWrite;
   logic ifidFlush, idexFlush, exmemFlush;
   logic busy, done;

   assign rtMatchRs = (hz.IDEX_RegisterRt_in == hz.IFID_RegisterRs_in);
   assign rtMatchRt = hz.IFID_UsesRt_in &
                      (hz.IDEX_RegisterRt_in == hz.IFID_RegisterRt_in);
   // Register 0 is hard-wired zero, so a load into it never creates a hazard.
   assign loadUse   = hz.IDEX_MemRead_in & (hz.IDEX_RegisterRt_in != 5'd0) &
                      (rtMatchRs | rtMatchRt);

   // State and countdown registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         cnt   <= 8'd0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // Next state and all hazard outputs, combinational with no added latency.
   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      pcWrite    = 1'b1;
      ifidWrite  = 1'b1;
      idexWrite  = 1'b1;
      ifidFlush  = 1'b0;
      idexFlush  = 1'b0;
      exmemFlush = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;

      case (state)
         RUN: begin
            if (hz.Branch_taken_in) begin
               ifidFlush = 1'b1;
               idexFlush = 1'b1;
            end else if (hz.MulDiv_start_in) begin
               pcWrite    = 1'b0;
               ifidWrite  = 1'b0;
               idexWrite  = 1'b0;
               exmemFlush = 1'b1;
               busy       = 1'b1;
               cntNext    = LAT_M1;
               stateNext  = BUSY;
            end else if (loadUse) begin
               // A jump in ID is held back; it is seen again next cycle.
               pcWrite   = 1'b0;
               ifidWrite = 1'b0;
               idexFlush = 1'b1;
            end else if (hz.Jump_in) begin
               ifidFlush = 1'b1;
            end
         end
         BUSY: begin
            if (cnt != 8'd0) begin
               pcWrite    = 1'b0;
               ifidWrite  = 1'b0;
               idexWrite  = 1'b0;
               exmemFlush = 1'b1;
               busy       = 1'b1;
               cntNext    = cnt - 8'd1;
            end else begin
               // Done cycle ignores a new start, so there is no re-trigger.
               done      = 1'b1;
               stateNext = RUN;
            end
         end
         default: begin
            stateNext = RUN;
            cntNext   = 8'd0;
         end
      endcase

      // Reset freezes the pipeline outright, not just the controller state.
      if (reset) begin
         stateNext  = RUN;
         cntNext    = 8'd0;
         pcWrite    = 1'b0;
         ifidWrite  = 1'b0;
         idexWrite  = 1'b0;
         ifidFlush  = 1'b0;
         idexFlush  = 1'b0;
         exmemFlush = 1'b0;
         busy       = 1'b0;
         done       = 1'b0;
      end
   end

   // Saturating count of cycles where the PC was held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stallCnt <= 16'd0;
      end else if (!pcWrite && (stallCnt != 16'hFFFF)) begin
         stallCnt <= stallCnt + 16'd1;
      end
   end

   assign hz.PcWrite_out     = pcWrite;
   assign hz.IFID_Write_out  = ifidWrite;
   assign hz.IDEX_Write_out  = idexWrite;
   assign hz.IFID_Flush_out  = ifidFlush;
   assign hz.IDEX_Flush_out  = idexFlush;
   assign hz.EXMEM_Flush_out = exmemFlush;
   assign hz.MulDiv_busy_out = busy;
   assign hz.MulDiv_done_out = done;
   assign hz.Stall_cnt_out   = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// mult/div, reset and saturation sequences, and randomized traffic compared
// against a cycle-age reference model.
module tb_hazard_ctrl;

   localparam int LAT = 32;

   // Output vector order: {PcWrite, IFID_Write, IDEX_Write, IFID_Flush,
   //                       IDEX_Flush, EXMEM_Flush, busy, done}
   localparam logic [7:0] O_DEF   = 8'b1110_0000;
   localparam logic [7:0] O_LU    = 8'b0010_1000;
   localparam logic [7:0] O_BR    = 8'b1111_1000;
   localparam logic [7:0] O_JMP   = 8'b1111_0000;
   localparam logic [7:0] O_MD    = 8'b0000_0110;
   localparam logic [7:0] O_DONE  = 8'b1110_0001;
   localparam logic [7:0] O_RESET = 8'b0000_0000;

   typedef struct packed {
      logic       memRead;
      logic [4:0] idexRt;
      logic [4:0] ifidRs;
      logic [4:0] ifidRt;
      logic       usesRt;
      logic       branch;
      logic       jump;
      logic       start;
   } stim_t;

   typedef struct {
      stim_t      stim;
      logic [7:0] expOut;
   } vec_t;

   logic clk;
   logic reset;
   hazard_if hz();

   hazard_ctrl #(.MULDIV_LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: age of the running mult/div in cycles (-1 = none).
   int mAge   = -1;
   int mStall = 0;

   localparam stim_t IDLE = '0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] getOut();
      return {hz.PcWrite_out, hz.IFID_Write_out, hz.IDEX_Write_out,
              hz.IFID_Flush_out, hz.IDEX_Flush_out, hz.EXMEM_Flush_out,
              hz.MulDiv_busy_out, hz.MulDiv_done_out};
   endfunction

   function automatic logic isLoadUse(input stim_t s);
      return s.memRead && (s.idexRt != 0) &&
             ((s.idexRt == s.ifidRs) || (s.usesRt && (s.idexRt == s.ifidRt)));
   endfunction

   task automatic drive(input stim_t s);
      hz.IDEX_MemRead_in    = s.memRead;
      hz.IDEX_RegisterRt_in = s.idexRt;
      hz.IFID_RegisterRs_in = s.ifidRs;
      hz.IFID_RegisterRt_in = s.ifidRt;
      hz.IFID_UsesRt_in     = s.usesRt;
      hz.Branch_taken_in    = s.branch;
      hz.Jump_in            = s.jump;
      hz.MulDiv_start_in    = s.start;
   endtask

   // One clock: drive at edge+1, check mid-cycle, then advance the model.
   task automatic doCycle(input stim_t s, input string nm, output logic [7:0] got);
      logic [7:0] exp;
      drive(s);
      #4;
      if (mAge >= 0 && mAge < LAT)      exp = O_MD;
      else if (mAge == LAT)             exp = O_DONE;
      else if (s.branch)                exp = O_BR;
      else if (s.start) begin           exp = O_MD; mAge = 0; end
      else if (isLoadUse(s))            exp = O_LU;
      else if (s.jump)                  exp = O_JMP;
      else                              exp = O_DEF;
      got = getOut();
      chk({nm, "_out"}, 32'(got), 32'(exp));
      chk({nm, "_stall"}, 32'(hz.Stall_cnt_out), 32'(mStall));
      @(posedge clk);
      #1;
      if (!exp[7] && mStall < 65535) mStall++;
      if (mAge >= 0) begin
         mAge++;
         if (mAge > LAT) mAge = -1;
      end
   endtask

   vec_t vecs[11];

   initial begin
      logic [7:0] got;
      stim_t s;
      int busyCnt, doneAt, stallStart;

      vecs[0]  = '{stim: '{1, 5'd5, 5'd5, 5'd9, 0, 0, 0, 0}, expOut: O_LU};
      vecs[1]  = '{stim: '{1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0}, expOut: O_DEF};
      vecs[2]  = '{stim: '{1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 0}, expOut: O_LU};
      vecs[3]  = '{stim: '{1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0}, expOut: O_DEF};
      vecs[4]  = '{stim: '{1, 5'd5, 5'd5, 5'd1, 0, 1, 1, 0}, expOut: O_BR};
      vecs[5]  = '{stim: '{1, 5'd5, 5'd5, 5'd1, 0, 0, 1, 0}, expOut: O_LU};
      vecs[6]  = '{stim: '{0, 5'd0, 5'd2, 5'd3, 0, 0, 1, 0}, expOut: O_JMP};
      vecs[7]  = '{stim: '{0, 5'd5, 5'd5, 5'd5, 1, 0, 0, 0}, expOut: O_DEF};
      vecs[8]  = '{stim: '{1, 5'd4, 5'd5, 5'd6, 1, 0, 0, 0}, expOut: O_DEF};
      vecs[9]  = '{stim: IDLE, expOut: O_DEF};
      vecs[10] = '{stim: '{1, 5'd0, 5'd1, 5'd0, 1, 0, 0, 0}, expOut: O_DEF};

      // Power-on reset.
      reset = 1'b1;
      drive(IDLE);
      @(posedge clk);
      #1;
      chk("por_out", 32'(getOut()), 32'(O_RESET));
      @(posedge clk);
      #1;
      chk("por_stall", 32'(hz.Stall_cnt_out), 32'd0);
      reset = 1'b0;

      // Directed single-cycle hazard vectors.
      for (int i = 0; i < 11; i++) begin
         doCycle(vecs[i].stim, "vec", got);
         chk($sformatf("vec%0d", i), 32'(got), 32'(vecs[i].expOut));
         if (i == 0) chk("lu_first_stall", 32'(hz.Stall_cnt_out), 32'd1);
      end
      chk("vec_stall_total", 32'(hz.Stall_cnt_out), 32'd3);

      // Mult/div: start at T, stall T..T+31, done at T+32, start in done ignored.
      busyCnt = 0;
      doneAt = -1;
      stallStart = mStall;
      for (int k = 0; k <= LAT + 1; k++) begin
         s = IDLE;
         if (k == 0 || k == LAT) s.start = 1'b1;
         if (k > 0 && k < LAT) begin
            s.branch  = k[0];
            s.memRead = 1'b1; s.idexRt = 5'd3; s.ifidRs = 5'd3;
         end
         doCycle(s, "md", got);
         if (got[1] && !got[7]) busyCnt++;
         if (got[0]) doneAt = k;
      end
      chk("md_busy_cycles", 32'(busyCnt), 32'(LAT));
      chk("md_done_at", 32'(doneAt), 32'(LAT));
      chk("md_stall_delta", 32'(hz.Stall_cnt_out), 32'(stallStart + LAT));

      // Reset asserted mid mult/div aborts it with no done pulse.
      s = IDLE;
      s.start = 1'b1;
      doCycle(s, "rmd", got);
      for (int k = 1; k < 10; k++) doCycle(IDLE, "rmd", got);
      reset = 1'b1;
      #1;
      chk("rst_async_out", 32'(getOut()), 32'(O_RESET));
      chk("rst_async_stall", 32'(hz.Stall_cnt_out), 32'd0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("rst_hold_out", 32'(getOut()), 32'(O_RESET));
      reset = 1'b0;
      mAge = -1;
      mStall = 0;
      doCycle(IDLE, "rst_release", got);
      chk("rst_first_pcwrite", 32'(got[7]), 32'd1);
      for (int k = 0; k < LAT + 2; k++) doCycle(IDLE, "rst_nodone", got);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         s.memRead = 1'($urandom_range(0, 1));
         s.idexRt  = 5'($urandom_range(0, 3));
         s.ifidRs  = 5'($urandom_range(0, 3));
         s.ifidRt  = 5'($urandom_range(0, 3));
         s.usesRt  = 1'($urandom_range(0, 1));
         s.branch  = ($urandom_range(0, 7) == 0);
         s.jump    = ($urandom_range(0, 3) == 0);
         s.start   = ($urandom_range(0, 19) == 0);
         doCycle(s, "rnd", got);
      end

      // Saturation: hold a load-use stall for 70000 cycles.
      s = IDLE;
      s.memRead = 1'b1; s.idexRt = 5'd5; s.ifidRs = 5'd5;
      drive(s);
      repeat (70000) @(posedge clk);
      #1;
      chk("sat_value", 32'(hz.Stall_cnt_out), 32'h0000FFFF);
      @(posedge clk);
      #1;
      chk("sat_hold", 32'(hz.Stall_cnt_out), 32'h0000FFFF);
      chk("sat_still_stalling", 32'(getOut()), 32'(O_LU));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
